// File: rtl/sdram_req_gen_pkg.sv
// Shared constants and channel state encoding for the SDRAM burst
// request generator.
package sdram_req_gen_pkg;
  localparam int BURST_LEN    = 512;
  localparam int FIFO_DEPTH   = 1024;
  localparam int FRAME_BURSTS = 600;
  localparam int AW           = 11;
  localparam int PW           = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_UPD  = 2'd2
  } chan_st_t;
endpackage

// File: rtl/sdram_req_gen_if.sv
// FIFO levels, burst handshakes and frame addresses between the
// request generator and the SDRAM controller.
interface sdram_req_gen_if;
  import sdram_req_gen_pkg::*;

  logic          init_done;
  logic [AW-1:0] wfifo_rdusedw;
  logic [AW-1:0] rfifo_wrusedw;
  logic          wr_sdram_ack;
  logic          rd_sdram_ack;
  logic          wr_sdram_req;
  logic          rd_sdram_req;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          wr_frame_done;

  modport master (
    input  init_done, wfifo_rdusedw, rfifo_wrusedw,
    input  wr_sdram_ack, rd_sdram_ack,
    output wr_sdram_req, rd_sdram_req,
    output wr_addr, rd_addr, rd_valid, wr_frame_done
  );

  modport slave (
    output init_done, wfifo_rdusedw, rfifo_wrusedw,
    output wr_sdram_ack, rd_sdram_ack,
    input  wr_sdram_req, rd_sdram_req,
    input  wr_addr, rd_addr, rd_valid, wr_frame_done
  );
endinterface

// File: rtl/sdram_burst_chan.sv
// One burst channel: IDLE/REQ/UPD handshake FSM and a page counter
// that wraps once per frame.
module sdram_burst_chan
  import sdram_req_gen_pkg::*;
#(
  parameter int PAGE_W   = 10,
  parameter int N_BURSTS = 600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_ack,
  output logic              o_req,
  output logic              o_last,
  output logic [PAGE_W-1:0] o_page
);
  localparam logic [PAGE_W-1:0] LAST = PAGE_W'(N_BURSTS - 1);

  chan_st_t          r_st;
  logic              r_req;
  logic              r_last;
  logic [PAGE_W-1:0] r_page;
  logic              w_at_last;

  assign w_at_last = (r_page == LAST);

  // r_last is high only during the UPD cycle of a frame's final burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= ST_IDLE;
      r_req  <= 1'b0;
      r_last <= 1'b0;
      r_page <= '0;
    end else begin
      case (r_st)
        ST_IDLE: begin
          if (i_start) begin
            r_st  <= ST_REQ;
            r_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_ack) begin
            r_st   <= ST_UPD;
            r_req  <= 1'b0;
            r_last <= w_at_last;
          end
        end
        ST_UPD: begin
          r_st   <= ST_IDLE;
          r_last <= 1'b0;
          r_page <= w_at_last ? '0 : r_page + 1'b1;
        end
        default: begin
          r_st   <= ST_IDLE;
          r_req  <= 1'b0;
          r_last <= 1'b0;
        end
      endcase
    end
  end

  assign o_req  = r_req;
  assign o_last = r_last;
  assign o_page = r_page;
endmodule

// File: rtl/sdram_req_gen.sv
// Ping-pong frame buffer request generator: FIFO-level thresholds
// start write/read bursts; buffer bits swap at frame boundaries.
module sdram_req_gen #(
  parameter int BURST_LEN    = sdram_req_gen_pkg::BURST_LEN,
  parameter int FIFO_DEPTH   = sdram_req_gen_pkg::FIFO_DEPTH,
  parameter int FRAME_BURSTS = sdram_req_gen_pkg::FRAME_BURSTS
) (
  input logic             clk,
  input logic             rst_n,
  sdram_req_gen_if.master bus
);
  import sdram_req_gen_pkg::*;

  localparam logic [AW-1:0] WR_TH = AW'(BURST_LEN);
  localparam logic [AW-1:0] RD_TH = AW'(FIFO_DEPTH - BURST_LEN);

  logic          w_wr_start;
  logic          w_rd_start;
  logic          w_wr_last;
  logic          w_rd_last;
  logic [PW-1:0] w_wr_page;
  logic [PW-1:0] w_rd_page;
  logic          r_wr_buf;
  logic          r_rd_buf;
  logic          r_rd_valid;

  assign w_wr_start = bus.init_done &
                      (bus.wfifo_rdusedw >= WR_TH);
  assign w_rd_start = bus.init_done & r_rd_valid &
                      (bus.rfifo_wrusedw <= RD_TH);

  sdram_burst_chan #(
    .PAGE_W   (PW),
    .N_BURSTS (FRAME_BURSTS)
  ) u_wr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_wr_start),
    .i_ack   (bus.wr_sdram_ack),
    .o_req   (bus.wr_sdram_req),
    .o_last  (w_wr_last),
    .o_page  (w_wr_page)
  );

  sdram_burst_chan #(
    .PAGE_W   (PW),
    .N_BURSTS (FRAME_BURSTS)
  ) u_rd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_rd_start),
    .i_ack   (bus.rd_sdram_ack),
    .o_req   (bus.rd_sdram_req),
    .o_last  (w_rd_last),
    .o_page  (w_rd_page)
  );

  // Reader always follows the most recently completed write buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_buf   <= 1'b0;
      r_rd_buf   <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_last) begin
        r_wr_buf   <= ~r_wr_buf;
        r_rd_valid <= 1'b1;
      end
      if (w_rd_last)
        r_rd_buf <= w_wr_last ? r_wr_buf : ~r_wr_buf;
      else if (w_wr_last && !r_rd_valid)
        r_rd_buf <= r_wr_buf;
    end
  end

  assign bus.wr_addr       = {r_wr_buf, w_wr_page};
  assign bus.rd_addr       = {r_rd_buf, w_rd_page};
  assign bus.rd_valid      = r_rd_valid;
  assign bus.wr_frame_done = w_wr_last;
endmodule
